// File: rtl/adder_arb_pkg.sv
// Shared constants and the requester-index type for the adder arbiter.
package adder_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef logic [ID_W-1:0] req_id_t;
endpackage

// File: rtl/adder_arbiter_adder.sv
// Combinational adder: zero-extends both operands to w bits, so w = n+1 exposes the carry.
module adder_arbiter_adder #(
  parameter int n = 32,
  parameter int w = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [w-1:0] sum
);
  assign sum = w'(a) + w'(b);
endmodule

// File: rtl/adder_arbiter.sv
// Four requesters share one adder through a round-robin arbiter and a one-deep result register.
// Optional feature: define ADDER_ARB_CARRY_EN to add the registered res_carry output.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int n = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*n-1:0] req_a,
  input  logic [NUM_REQ*n-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  output logic [n-1:0]         res_data,
  output logic [ID_W-1:0]      res_id,
  input  logic                 res_ready
`ifdef ADDER_ARB_CARRY_EN
  ,
  output logic                 res_carry
`endif
);

`ifdef ADDER_ARB_CARRY_EN
  localparam int SUM_W = n + 1;
`else
  localparam int SUM_W = n;
`endif

  req_id_t            ptr_r;
  req_id_t            gnt_id_s;
  logic               gnt_vld_s;
  logic               free_s;
  logic [n-1:0]       op_a_s;
  logic [n-1:0]       op_b_s;
  logic [SUM_W-1:0]   sum_s;

  assign free_s = !res_valid || res_ready;

  // Round-robin pick: scan from lowest priority up so the highest-priority valid requester wins.
  always_comb begin
    req_id_t idx_v;
    gnt_vld_s = 1'b0;
    gnt_id_s  = '0;
    idx_v     = '0;
    if (free_s && !rst) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx_v = ptr_r + req_id_t'(k);
        if (req_valid[idx_v]) begin
          gnt_vld_s = 1'b1;
          gnt_id_s  = idx_v;
        end else begin
          gnt_vld_s = gnt_vld_s;
        end
      end
    end else begin
      gnt_vld_s = 1'b0;
    end
  end

  // One-hot grant decode.
  always_comb begin
    req_ready = 4'b0000;
    if (gnt_vld_s) begin
      req_ready = 4'b0001 << gnt_id_s;
    end else begin
      req_ready = 4'b0000;
    end
  end

  assign op_a_s = req_a[gnt_id_s*n +: n];
  assign op_b_s = req_b[gnt_id_s*n +: n];

  adder_arbiter_adder #(
    .n (n),
    .w (SUM_W)
  ) u_adder (
    .a   (op_a_s),
    .b   (op_b_s),
    .sum (sum_s)
  );

  // Result register and round-robin pointer; data/id hold when the result drains with no new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      ptr_r     <= '0;
`ifdef ADDER_ARB_CARRY_EN
      res_carry <= 1'b0;
`endif
    end else if (gnt_vld_s) begin
      res_valid <= 1'b1;
      res_data  <= sum_s[n-1:0];
      res_id    <= gnt_id_s;
      ptr_r     <= gnt_id_s + 2'd1;
`ifdef ADDER_ARB_CARRY_EN
      res_carry <= sum_s[n];
`endif
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized plus directed bench for adder_arbiter against a cycle-level reference model.
module tb_adder_arbiter;
  localparam int n = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [4*n-1:0] req_a;
  logic [4*n-1:0] req_b;
  logic [3:0]     req_ready;
  logic           res_valid;
  logic [n-1:0]   res_data;
  logic [1:0]     res_id;
  logic           res_ready;
`ifdef ADDER_ARB_CARRY_EN
  logic           res_carry;
`endif

  adder_arbiter #(.n(n)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
`ifdef ADDER_ARB_CARRY_EN
    ,
    .res_carry (res_carry)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_ptr   = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_id    = 0;
  bit          m_carry = 1'b0;
  int          last_g  = -1;

  // per-requester stimulus
  bit          va [4];
  logic [31:0] oa [4];
  logic [31:0] ob [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = va[i];
      req_a[i*n +: n]    = oa[i];
      req_b[i*n +: n]    = ob[i];
    end
  endtask

  // One clock: predict and check the grant, advance the model, check the result register.
  task automatic step();
    int g;
    bit free;
    logic [3:0] exp_rdy;
    logic [32:0] s;
    #1;
    free = !m_valid || res_ready;
    g = -1;
    if (!rst && free) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_carry = 1'b0;
    end else if (g >= 0) begin
      s = {1'b0, req_a[g*n +: n]} + {1'b0, req_b[g*n +: n]};
      m_valid = 1'b1; m_data = s[31:0]; m_carry = s[32]; m_id = g;
      m_ptr = (g + 1) % 4;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("res_valid", {63'd0, res_valid}, {63'd0, m_valid});
    check("res_data",  {32'd0, res_data},  {32'd0, m_data});
    check("res_id",    {62'd0, res_id},    64'(m_id));
`ifdef ADDER_ARB_CARRY_EN
    check("res_carry", {63'd0, res_carry}, {63'd0, m_carry});
`endif
    last_g = g;
  endtask

  task automatic set_all(input bit v3, input bit v2, input bit v1, input bit v0);
    va[3] = v3; va[2] = v2; va[1] = v1; va[0] = v0;
    drive();
  endtask

  initial begin
    rst = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      va[i] = 1'b1;
      oa[i] = 32'(i * 100 + 7);
      ob[i] = 32'(i * 3 + 1);
    end
    drive();
    #2;

    // reset with every requester asking
    step(); step();

    // single request from requester 0
    rst = 1'b0;
    set_all(1'b0, 1'b0, 1'b0, 1'b1);
    oa[0] = 32'd4542; ob[0] = 32'd5482; drive();
    step();
    check("single_sum", {32'd0, res_data}, 64'd10024);
    check("single_id",  {62'd0, res_id},   64'd0);
    set_all(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // fairness from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    set_all(1'b1, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("fair_id", {62'd0, res_id}, 64'(c % 4));
    end

    // backpressure then release
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    res_ready = 1'b1;
    step();
    check("bp_release_grant", 64'(last_g), 64'd1);

    // wrap-around and carry
    rst = 1'b1; step(); rst = 1'b0;
    set_all(1'b0, 1'b0, 1'b0, 1'b1);
    oa[0] = 32'hFFFFFFFF; ob[0] = 32'd1; drive();
    step();
    check("wrap_zero", {32'd0, res_data}, 64'd0);
`ifdef ADDER_ARB_CARRY_EN
    check("wrap_carry", {63'd0, res_carry}, 64'd1);
`endif

    // reset mid-stream with a pending result
    set_all(1'b0, 1'b0, 1'b1, 1'b0);
    res_ready = 1'b0;
    step();
    set_all(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    check("rst_drop_valid", {63'd0, res_valid}, 64'd0);
    rst = 1'b0; res_ready = 1'b1;
    step();
    check("rst_first_grant", 64'(last_g), 64'd1);

    // randomized traffic; pending requesters keep their operands until granted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(va[i] && last_g != i && req_valid[i])) begin
          va[i] = ($urandom_range(0, 9) < 6);
          oa[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
          ob[i] = $urandom;
        end
      end
      drive();
      res_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 49) == 0);
      step();
      if (rst) begin
        for (int i = 0; i < 4; i++) va[i] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: n, 32, operand and result width in bits.
REQ-002 Port: clk  input  1  sole clock, rising-edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  input  4  per-requester operand-valid; bit i belongs to requester i.
REQ-005 Port: req_a  input  4*n  requester operand A, requester i in bits [i*n +: n].
REQ-006 Port: req_b  input  4*n  requester operand B, same packing as req_a.
REQ-007 Port: req_ready  output  4  one-hot grant; handshake completes on req_valid[i] & req_ready[i] at a rising edge.
REQ-008 Port: res_valid  output  1  registered result valid.
REQ-009 Port: res_data  output  n  registered sum.
REQ-010 Port: res_id  output  2  index of the requester that owns res_data.
REQ-011 Port: res_ready  input  1  consumer accepts the result when res_valid & res_ready.

Function
REQ-012 Block shares one n-bit adder among 4 requesters; at most one operand pair is accepted per cycle.
REQ-013 Output register "free" = !res_valid | res_ready; no grant is issued unless free and rst=0.
REQ-014 Round-robin pointer ptr (2 bits): requester ptr has highest priority, then ptr+1, ptr+2, ptr+3 (mod 4).
REQ-015 req_ready is combinational from req_valid, ptr and free: exactly the highest-priority valid requester when free; all zero otherwise.
REQ-016 On grant of requester g: ptr <= (g+1) mod 4; with no grant, ptr holds.
REQ-017 Latency 1: a grant at edge t gives res_valid=1, res_data=(A+B) mod 2^n, res_id=g after edge t.
REQ-018 With res_valid=1 and res_ready=0: res_data, res_id and res_valid hold, and req_ready=0.
REQ-019 With res_valid=1, res_ready=1 and a new grant in the same cycle: the register reloads with no bubble, giving one result per cycle sustained.
REQ-020 With res_valid=1, res_ready=1 and no grant: res_valid <= 0, and res_data/res_id hold their last value.
REQ-021 Requesters hold req_a/req_b stable while req_valid=1 until granted; the block does not latch unselected operands.
REQ-022 Wrap-around: carry out of bit n-1 is discarded in res_data.

Reset
REQ-023 While rst=1 at an edge: res_valid<=0, res_data<=0, res_id<=0, ptr<=0; req_ready forced 0 combinationally.
REQ-024 Reset mid-operation discards any pending result; no grant is issued in a cycle with rst=1.

Configuration
REQ-025 Macro ADDER_ARB_CARRY_EN defined: extra port res_carry (output, 1 bit) is registered alongside res_data and equals the carry out of bit n-1, with reset value 0.
REQ-026 Macro ADDER_ARB_CARRY_EN undefined: the res_carry port and its register do not exist; all other behaviour is identical.

Structure
REQ-027 Package adder_arb_pkg holds NUM_REQ=4, ID_W=2 and the 2-bit requester-index typedef.
REQ-028 Exactly one sub-module is instantiated: the existing n-bit combinational adder, fed by the granted operand mux.
REQ-029 Arbitration, the pointer and the output register live in adder_arbiter itself.

Verification
REQ-030 Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, res_valid=0, ptr=0 throughout.
REQ-031 Single request: requester 0 A=4542, B=5482, res_ready=1 -> req_ready=0001 for one cycle; next cycle res_valid=1, res_data=10024, res_id=0.
REQ-032 Fairness: req_valid=1111 held, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; res_id sequence is 0,1,2,3,0 one cycle later; no idle cycles.
REQ-033 Backpressure: res_valid=1, res_ready=0 for 3 cycles -> req_ready=0000 and res_data stable; res_ready=1 -> the next grant occurs in that same cycle.
REQ-034 Wrap/carry: A=32'hFFFFFFFF, B=32'd1 -> res_data=0, and res_carry=1 when ADDER_ARB_CARRY_EN is defined.
REQ-035 Reset mid-stream: rst=1 while res_valid=1 and req_valid=0110 -> res_valid=0 after the edge; after release, requester 1 is granted first (ptr=0).
